// File: rtl/axi_lite_master_port.sv
// Single-outstanding AXI4-lite master: turns one command into a read or write
// transaction with a per-phase wait timeout and a one-cycle response pulse.
module axi_lite_master_port #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   // command side
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   // response side
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_timeout,
   // AXI4-lite write channels
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   // AXI4-lite read channels
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic [31:0] m_axi_rdata
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_REQ  = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_DATA = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_timeout_q, rsp_timeout_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs, expired, waiting;

   // Valids and readies decode from state only, so no valid ever waits on a ready.
   assign cmd_ready     = (state_q == S_IDLE);
   assign rsp_valid     = (state_q == S_DONE);
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign m_axi_awvalid = (state_q == S_WR_REQ) && !aw_done_q;
   assign m_axi_wvalid  = (state_q == S_WR_REQ) && !w_done_q;
   assign m_axi_bready  = (state_q == S_WR_RESP);
   assign m_axi_arvalid = (state_q == S_RD_REQ);
   assign m_axi_rready  = (state_q == S_RD_DATA);
   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_arprot  = 3'b000;

   assign aw_hs   = m_axi_awvalid && m_axi_awready;
   assign w_hs    = m_axi_wvalid && m_axi_wready;
   assign b_hs    = m_axi_bvalid && m_axi_bready;
   assign ar_hs   = m_axi_arvalid && m_axi_arready;
   assign r_hs    = m_axi_rvalid && m_axi_rready;
   assign expired = (cnt_q == CNT_LAST);
   assign waiting = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                    (state_q == S_RD_REQ) || (state_q == S_RD_DATA);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_write ? S_WR_REQ : S_RD_REQ;
            end
         end
         S_WR_REQ: begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            // A handshake landing on the expiry cycle wins over the timeout.
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d = S_WR_RESP;
            end else if (expired) begin
               state_d       = S_DONE;
               rsp_rdata_d   = 32'h0;
               rsp_timeout_d = 1'b1;
            end
         end
         S_WR_RESP: begin
            if (b_hs) begin
               state_d       = S_DONE;
               rsp_rdata_d   = 32'h0;
               rsp_timeout_d = 1'b0;
            end else if (expired) begin
               state_d       = S_DONE;
               rsp_rdata_d   = 32'h0;
               rsp_timeout_d = 1'b1;
            end
         end
         S_RD_REQ: begin
            if (ar_hs) begin
               state_d = S_RD_DATA;
            end else if (expired) begin
               state_d       = S_DONE;
               rsp_rdata_d   = 32'h0;
               rsp_timeout_d = 1'b1;
            end
         end
         S_RD_DATA: begin
            if (r_hs) begin
               state_d       = S_DONE;
               rsp_rdata_d   = m_axi_rdata;
               rsp_timeout_d = 1'b0;
            end else if (expired) begin
               state_d       = S_DONE;
               rsp_rdata_d   = 32'h0;
               rsp_timeout_d = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q || !waiting) cnt_d = 16'h0;
      else                                cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: datapath registers are reset too, so the AXI address/data outputs read 0 after reset.
         state_q       <= S_IDLE;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         wstrb_q       <= 4'h0;
         aw_done_q     <= 1'b0;
         w_done_q      <= 1'b0;
         cnt_q         <= 16'h0;
         rsp_rdata_q   <= 32'h0;
         rsp_timeout_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         aw_done_q     <= aw_done_d;
         w_done_q      <= w_done_d;
         cnt_q         <= cnt_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Bench for axi_lite_master_port: a delay-programmable AXI slave plus a
// transaction-level model predicting response cycle, data, timeout and valid durations.
module tb_axi_lite_master_port;

   localparam int T = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_timeout;
   logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
   logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
   logic [31:0] m_axi_rdata = '0;
   logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic [2:0]  m_axi_awprot, m_axi_arprot;

   always #5 clk = ~clk;

   axi_lite_master_port #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata)
   );

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Slave programming: each delay is the number of cycles the channel waits
   // (with valid/ready from the master present) before completing its handshake.
   int          dly_aw = 0, dly_w = 0, dly_b = 0, dly_ar = 0, dly_r = 0;
   logic [31:0] rd_val = '0, exp_addr = '0, exp_wdata = '0;
   logic [3:0]  exp_wstrb = '0;
   int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
   int          aw_hi = 0, w_hi = 0, b_hi = 0, ar_hi = 0, r_hi = 0;

   always @(negedge clk) begin
      if (m_axi_awvalid) begin
         m_axi_awready = (aw_cnt == dly_aw);
         if (m_axi_awready) begin
            check("awaddr", m_axi_awaddr, exp_addr);
            check("awprot", 32'(m_axi_awprot), 32'h0);
         end
         aw_cnt++; aw_hi++;
      end else begin
         m_axi_awready = 1'($urandom_range(0, 1));
         aw_cnt = 0;
      end
      if (m_axi_wvalid) begin
         m_axi_wready = (w_cnt == dly_w);
         if (m_axi_wready) begin
            check("wdata", m_axi_wdata, exp_wdata);
            check("wstrb", 32'(m_axi_wstrb), 32'(exp_wstrb));
         end
         w_cnt++; w_hi++;
      end else begin
         m_axi_wready = 1'($urandom_range(0, 1));
         w_cnt = 0;
      end
      if (m_axi_arvalid) begin
         m_axi_arready = (ar_cnt == dly_ar);
         if (m_axi_arready) begin
            check("araddr", m_axi_araddr, exp_addr);
            check("arprot", 32'(m_axi_arprot), 32'h0);
         end
         ar_cnt++; ar_hi++;
      end else begin
         m_axi_arready = 1'b0;
         ar_cnt = 0;
      end
      // Stray bvalid/rvalid while the master is not ready must be ignored.
      if (m_axi_bready) begin
         m_axi_bvalid = (b_cnt == dly_b);
         b_cnt++; b_hi++;
      end else begin
         m_axi_bvalid = ($urandom_range(0, 3) == 0);
         b_cnt = 0;
      end
      if (m_axi_rready) begin
         m_axi_rvalid = (r_cnt == dly_r);
         m_axi_rdata  = m_axi_rvalid ? rd_val : $urandom();
         r_cnt++; r_hi++;
      end else begin
         m_axi_rvalid = ($urandom_range(0, 3) == 0);
         m_axi_rdata  = $urandom();
         r_cnt = 0;
      end
      check("overlap", 32'((m_axi_awvalid | m_axi_wvalid | m_axi_bready) &
                           (m_axi_arvalid | m_axi_rready)), 32'h0);
      check("idle_axi", 32'(cmd_ready & (m_axi_awvalid | m_axi_wvalid | m_axi_bready |
                                         m_axi_arvalid | m_axi_rready)), 32'h0);
   end

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic check_reset_outputs();
      check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_timeout", 32'(rsp_timeout), 32'h0);
      check("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'h0);
      check("rst_readies", 32'({m_axi_bready, m_axi_rready}), 32'h0);
      check("rst_awaddr", m_axi_awaddr, 32'h0);
      check("rst_araddr", m_axi_araddr, 32'h0);
      check("rst_wdata", m_axi_wdata, 32'h0);
      check("rst_wstrb", 32'(m_axi_wstrb), 32'h0);
   endtask

   // One command end to end. For writes d1/d2/d3 are the AW/W/B delays, for
   // reads d1/d3 are the AR/R delays. Called and returns at a falling edge.
   // Response cycle is counted with the first cycle after the accept edge as 1.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int d1, input int d2, input int d3,
                          input logic [31:0] rdv, input bit hold);
      int p1, p2, cyc, n;
      bit to;
      logic [31:0] exp_rd;
      int e_aw, e_w, e_b, e_ar, e_r;
      int s_aw, s_w, s_b, s_ar, s_r;

      // A phase lasts delay+1 cycles, or T cycles if the delay reaches T.
      p1 = wr ? imax(d1, d2) : d1;
      if (p1 < T) begin
         p1 = p1 + 1;
         p2 = (d3 < T) ? d3 + 1 : T;
         to = (d3 >= T);
      end else begin
         p1 = T;
         p2 = 0;
         to = 1'b1;
      end
      cyc    = p1 + p2 + 1;
      exp_rd = (wr || to) ? 32'h0 : rdv;
      e_aw = wr ? imin(d1 + 1, p1) : 0;
      e_w  = wr ? imin(d2 + 1, p1) : 0;
      e_b  = wr ? p2 : 0;
      e_ar = wr ? 0 : p1;
      e_r  = wr ? 0 : p2;

      dly_aw = d1; dly_w = d2; dly_b = d3; dly_ar = d1; dly_r = d3;
      rd_val = rdv; exp_addr = addr; exp_wdata = wdata; exp_wstrb = strb;
      s_aw = aw_hi; s_w = w_hi; s_b = b_hi; s_ar = ar_hi; s_r = r_hi;

      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", 32'(cmd_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rsp_cycle", 32'(n), 32'(cyc));
      check("rsp_timeout", 32'(rsp_timeout), 32'(to));
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("done_cmd_ready", 32'(cmd_ready), 32'h0);
      check("aw_high_cycles", 32'(aw_hi - s_aw), 32'(e_aw));
      check("w_high_cycles", 32'(w_hi - s_w), 32'(e_w));
      check("b_ready_cycles", 32'(b_hi - s_b), 32'(e_b));
      check("ar_high_cycles", 32'(ar_hi - s_ar), 32'(e_ar));
      check("r_ready_cycles", 32'(r_hi - s_r), 32'(e_r));
      @(negedge clk);
      check("rsp_one_pulse", 32'(rsp_valid), 32'h0);
      check("idle_cmd_ready", 32'(cmd_ready), 32'h1);
      check("rdata_hold", rsp_rdata, exp_rd);
      check("timeout_hold", 32'(rsp_timeout), 32'(to));
   endtask

   function automatic int rnd_dly();
      int r;
      r = $urandom_range(0, 15);
      if (r < 10) return r % 4;
      if (r < 13) return T - 1 + (r - 10);
      return $urandom_range(4, 6);
   endfunction

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      reset = 1'b0;

      // zero-wait read, then write with W lagging AW, W leading AW, both together
      run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
      run_txn(1'b1, 32'h0001_0004, 32'h1234_5678, 4'b0011, 0, 1, 0, 32'h0, 1'b0);
      run_txn(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 4'b1100, 3, 0, 1, 32'h0, 1'b0);
      run_txn(1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 4'b1111, 2, 2, 0, 32'h0, 1'b0);
      run_txn(1'b1, 32'h0000_0300, 32'h0000_0001, 4'b0001, 0, 0, 0, 32'h0, 1'b0);
      // timeout boundaries: delay T-1 completes on the expiry cycle, T aborts
      run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 100, 0, 0, 32'h1111_1111, 1'b0);
      run_txn(1'b0, 32'h0000_0024, 32'h0, 4'h0, T - 1, 0, 0, 32'h2222_2222, 1'b0);
      run_txn(1'b0, 32'h0000_0028, 32'h0, 4'h0, 0, 0, T - 1, 32'h3333_3333, 1'b0);
      run_txn(1'b0, 32'h0000_002C, 32'h0, 4'h0, 1, 0, T, 32'h4444_4444, 1'b0);
      run_txn(1'b1, 32'h0000_0400, 32'h5555_5555, 4'b0101, 0, T - 1, T - 1, 32'h0, 1'b0);
      run_txn(1'b1, 32'h0000_0404, 32'h6666_6666, 4'b1010, T, 0, 0, 32'h0, 1'b0);
      run_txn(1'b1, 32'h0000_0408, 32'h7777_7777, 4'b1111, 0, 0, T, 32'h0, 1'b0);

      // reset in RD_DATA with rvalid pending at the reset edge
      dly_ar = 0; dly_r = 1; rd_val = 32'h9999_9999; exp_addr = 32'h0000_0050;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0050;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!m_axi_rready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reach_rd_data", 32'(m_axi_rready), 32'h1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rvalid_pending", 32'({m_axi_rready, m_axi_rvalid}), 32'h3);
      @(negedge clk);
      check_reset_outputs();
      @(negedge clk);
      check("rst_no_rsp", 32'(rsp_valid), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
      run_txn(1'b0, 32'h0000_0054, 32'h0, 4'h0, 0, 0, 0, 32'hBEEF_0001, 1'b0);

      // back-to-back with cmd_valid held: second accept only after DONE
      run_txn(1'b0, 32'h0000_0060, 32'h0, 4'h0, 1, 0, 1, 32'h0BAD_F00D, 1'b1);
      run_txn(1'b0, 32'h0000_0060, 32'h0, 4'h0, 1, 0, 1, 32'h0BAD_F00D, 1'b0);

      for (int i = 0; i < 150; i++) begin
         run_txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom()),
                 rnd_dly(), rnd_dly(), rnd_dly(), $urandom(), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
